// File: rtl/clock_phase_gen.sv
// Four-phase clock sequencer: splits each processor cycle into FETCH/DECODE/MEM/WB and drives imem/dmem/processor/regfile clocks.
// Latency: all outputs registered; first edge after reset release enters FETCH with imem_clock=1.
// Backpressure: halt, sampled only on the last WB clock, parks the sequencer in HOLD with every clock low.
//
// Ports:
//   clock, reset (sync, active-high), halt  -- board clock, reset, stall request
//   step_req                                -- single-cycle step request (only with STEP_PHASE_EN)
//   processor_clock, imem_clock,
//   dmem_clock, regfile_clock               -- derived clocks, at most one group high at a time
//   phase (0..3), running, cycle_count      -- observation outputs
//
// Optional feature macro: STEP_PHASE_EN (adds step_req and single-cycle stepping out of HOLD).

module clock_phase_gen #(
    parameter int PHASE_LEN = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
`ifdef STEP_PHASE_EN
    input  logic             step_req,
`endif
    output logic             processor_clock,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             regfile_clock,
    output logic [1:0]       phase,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    generate
        if (PHASE_LEN < 1 || PHASE_LEN > 255) begin : g_bad_phase_len
            $error("clock_phase_gen: PHASE_LEN must be in 1..255");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("clock_phase_gen: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] PH_FETCH = 2'd0;
    localparam logic [1:0] PH_MEM   = 2'd2;
    localparam logic [1:0] PH_WB    = 2'd3;
    localparam logic [7:0] SUB_LAST = 8'(PHASE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             imem_q, imem_d;
    logic             dmem_q, dmem_d;
    logic             wb_q, wb_d;
    logic             running_q, running_d;
    logic             step_active;

`ifdef STEP_PHASE_EN
    // step_active_q marks a cycle launched by step_req; it always ends back in HOLD.
    // step_arm_q re-arms only after step_req is seen low, so a held request steps once.
    logic step_active_q, step_active_d;
    logic step_arm_q, step_arm_d;
    assign step_active = step_active_q;
`else
    assign step_active = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RST;
            phase_q   <= PH_FETCH;
            sub_q     <= 8'd0;
            cnt_q     <= '0;
            imem_q    <= 1'b0;
            dmem_q    <= 1'b0;
            wb_q      <= 1'b0;
            running_q <= 1'b0;
`ifdef STEP_PHASE_EN
            step_active_q <= 1'b0;
            step_arm_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sub_q     <= sub_d;
            cnt_q     <= cnt_d;
            imem_q    <= imem_d;
            dmem_q    <= dmem_d;
            wb_q      <= wb_d;
            running_q <= running_d;
`ifdef STEP_PHASE_EN
            step_active_q <= step_active_d;
            step_arm_q    <= step_arm_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
`ifdef STEP_PHASE_EN
        step_active_d = step_active_q;
        step_arm_d    = step_arm_q;
        if (!step_req) begin
            step_arm_d = 1'b1;
        end
`endif
        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
                phase_d = PH_FETCH;
                sub_d   = 8'd0;
            end
            ST_RUN: begin
                if (sub_q == SUB_LAST) begin
                    sub_d   = 8'd0;
                    phase_d = phase_q + 2'd1;
                    // Entering WB is the processor_clock rising edge.
                    if (phase_q == PH_MEM) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    // Last clock of WB: the only point where halt is honoured,
                    // so WB always completes in full before parking.
                    if (phase_q == PH_WB && (halt || step_active)) begin
                        state_d = ST_HOLD;
                        phase_d = PH_WB;
`ifdef STEP_PHASE_EN
                        step_active_d = 1'b0;
`endif
                    end
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!halt) begin
                    state_d = ST_RUN;
                    phase_d = PH_FETCH;
                    sub_d   = 8'd0;
`ifdef STEP_PHASE_EN
                end else if (step_req && step_arm_q) begin
                    state_d       = ST_RUN;
                    phase_d       = PH_FETCH;
                    sub_d         = 8'd0;
                    step_active_d = 1'b1;
                    step_arm_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_RST;
                phase_d = PH_FETCH;
                sub_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: computed from next state so every derived clock is a
    // flop output and changes only on a board clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        running_d = (state_d == ST_RUN);
        imem_d    = running_d && (phase_d == PH_FETCH);
        dmem_d    = running_d && (phase_d == PH_MEM);
        wb_d      = running_d && (phase_d == PH_WB);
    end

    assign imem_clock      = imem_q;
    assign dmem_clock      = dmem_q;
    assign processor_clock = wb_q;
    assign regfile_clock   = wb_q;
    assign phase           = phase_q;
    assign running         = running_q;
    assign cycle_count     = cnt_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Self-checking bench for clock_phase_gen: table-driven vectors on a PHASE_LEN=1/CNT_W=4
// instance plus hand sequences for halt, counter wrap, PHASE_LEN=3 timing, mid-MEM reset
// on a PHASE_LEN=2 instance, and (with STEP_PHASE_EN) single-cycle stepping.
module tb_clock_phase_gen;

    logic clk;
    logic r1, h1, r2, h2, r3, h3;
`ifdef STEP_PHASE_EN
    logic s1;
`endif
    logic im1, dm1, pc1, rc1, run1;
    logic [1:0] ph1;
    logic [3:0] cnt1;
    logic im2, dm2, pc2, rc2, run2;
    logic [1:0] ph2;
    logic [31:0] cnt2;
    logic im3, dm3, pc3, rc3, run3;
    logic [1:0] ph3;
    logic [31:0] cnt3;

    int checks = 0;
    int failures = 0;

    clock_phase_gen #(.PHASE_LEN(1), .CNT_W(4)) u1 (
        .clock(clk), .reset(r1), .halt(h1),
`ifdef STEP_PHASE_EN
        .step_req(s1),
`endif
        .processor_clock(pc1), .imem_clock(im1), .dmem_clock(dm1), .regfile_clock(rc1),
        .phase(ph1), .running(run1), .cycle_count(cnt1));

    clock_phase_gen #(.PHASE_LEN(2)) u2 (
        .clock(clk), .reset(r2), .halt(h2),
`ifdef STEP_PHASE_EN
        .step_req(1'b0),
`endif
        .processor_clock(pc2), .imem_clock(im2), .dmem_clock(dm2), .regfile_clock(rc2),
        .phase(ph2), .running(run2), .cycle_count(cnt2));

    clock_phase_gen #(.PHASE_LEN(3)) u3 (
        .clock(clk), .reset(r3), .halt(h3),
`ifdef STEP_PHASE_EN
        .step_req(1'b0),
`endif
        .processor_clock(pc3), .imem_clock(im3), .dmem_clock(dm3), .regfile_clock(rc3),
        .phase(ph3), .running(run3), .cycle_count(cnt3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // {imem, dmem, processor, regfile, running, phase}
    function automatic logic [6:0] out1();
        return {im1, dm1, pc1, rc1, run1, ph1};
    endfunction

    typedef struct {
        logic       rst;
        logic       hlt;
        logic [6:0] exp_out;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t tbl[16];

`ifdef STEP_PHASE_EN
    logic pim, pdm, ppc;
    int n_im, n_dm, n_pc;
    task automatic count_pulses(input int n, input logic sv);
        s1 = sv;
        for (int i = 0; i < n; i++) begin
            tick();
            if (im1 && !pim) n_im++;
            if (dm1 && !pdm) n_dm++;
            if (pc1 && !ppc) n_pc++;
            pim = im1; pdm = dm1; ppc = pc1;
        end
    endtask
`endif

    initial begin
        int hi_im, hi_dm, hi_pc, rs_im, rs_dm, rs_pc, excl_bad, rf_bad;
        logic lim, ldm, lpc;
        int waited;
        logic [3:0] base;

        r1 = 1'b1; h1 = 1'b0; r2 = 1'b1; h2 = 1'b0; r3 = 1'b1; h3 = 1'b0;
`ifdef STEP_PHASE_EN
        s1 = 1'b0;
`endif
        // rst, halt, {im,dm,pc,rc,run,ph}, cnt  -- value after the edge
        tbl[0]  = '{1'b1, 1'b0, 7'b0000_0_00, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 7'b0000_0_00, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 7'b0000_0_00, 4'd0};
        tbl[3]  = '{1'b0, 1'b0, 7'b1000_1_00, 4'd0};  // E0 FETCH
        tbl[4]  = '{1'b0, 1'b0, 7'b0000_1_01, 4'd0};  // E1 DECODE
        tbl[5]  = '{1'b0, 1'b0, 7'b0100_1_10, 4'd0};  // E2 MEM
        tbl[6]  = '{1'b0, 1'b0, 7'b0011_1_11, 4'd1};  // E3 WB
        tbl[7]  = '{1'b0, 1'b0, 7'b1000_1_00, 4'd1};  // E4 FETCH
        tbl[8]  = '{1'b0, 1'b0, 7'b0000_1_01, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 7'b0100_1_10, 4'd1};
        tbl[10] = '{1'b0, 1'b0, 7'b0011_1_11, 4'd2};
        tbl[11] = '{1'b0, 1'b0, 7'b1000_1_00, 4'd2};
        tbl[12] = '{1'b0, 1'b0, 7'b0000_1_01, 4'd2};
        tbl[13] = '{1'b0, 1'b1, 7'b0100_1_10, 4'd2};  // halt during MEM: ignored
        tbl[14] = '{1'b0, 1'b1, 7'b0011_1_11, 4'd3};  // WB runs in full
        tbl[15] = '{1'b0, 1'b1, 7'b0000_0_11, 4'd3};  // last WB clock sampled halt -> HOLD

        for (int i = 0; i < 16; i++) begin
            r1 = tbl[i].rst;
            h1 = tbl[i].hlt;
            tick();
            chk($sformatf("vec%0d_out", i), int'(out1()), int'(tbl[i].exp_out));
            chk($sformatf("vec%0d_cnt", i), int'(cnt1), int'(tbl[i].exp_cnt));
        end

        // Stay in HOLD for a further 9 clocks (10 total), then resume.
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_out", int'(out1()), int'(7'b0000_0_11));
        end
        h1 = 1'b0;
        tick();
        chk("resume_out", int'(out1()), int'(7'b1000_1_00));
        chk("resume_cnt", int'(cnt1), 3);

        // Counter wrap with CNT_W=4.
        r1 = 1'b1;
        tick();
        chk("wrap_reset_cnt", int'(cnt1), 0);
        r1 = 1'b0;
        for (int i = 0; i < 64; i++) tick();   // E0..E63, 16th WB entry at E63
        chk("wrap16_pc", int'(pc1), 1);
        chk("wrap16_cnt", int'(cnt1), 0);
        for (int i = 0; i < 4; i++) tick();    // 17th WB entry at E67
        chk("wrap17_pc", int'(pc1), 1);
        chk("wrap17_cnt", int'(cnt1), 1);

        // PHASE_LEN=3: 60 clocks from release, 5 processor cycles.
        hi_im = 0; hi_dm = 0; hi_pc = 0; rs_im = 0; rs_dm = 0; rs_pc = 0;
        excl_bad = 0; rf_bad = 0;
        lim = 1'b0; ldm = 1'b0; lpc = 1'b0;
        r3 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 0) chk("pl3_first_imem", int'(im3), 1);
            hi_im += int'(im3); hi_dm += int'(dm3); hi_pc += int'(pc3);
            if (im3 && !lim) rs_im++;
            if (dm3 && !ldm) rs_dm++;
            if (pc3 && !lpc) rs_pc++;
            if (int'(im3) + int'(dm3) + int'(pc3) > 1) excl_bad++;
            if (pc3 !== rc3) rf_bad++;
            lim = im3; ldm = dm3; lpc = pc3;
        end
        chk("pl3_imem_high", hi_im, 15);
        chk("pl3_dmem_high", hi_dm, 15);
        chk("pl3_proc_high", hi_pc, 15);
        chk("pl3_imem_pulses", rs_im, 5);
        chk("pl3_dmem_pulses", rs_dm, 5);
        chk("pl3_proc_pulses", rs_pc, 5);
        chk("pl3_exclusive", excl_bad, 0);
        chk("pl3_rf_eq_proc", rf_bad, 0);
        chk("pl3_cnt", int'(cnt3), 5);

        // PHASE_LEN=2: reset in the middle of MEM while dmem_clock is high.
        r2 = 1'b0;
        for (int i = 0; i < 13; i++) tick();   // E12: second MEM, first clock
        chk("pl2_mem_dmem", int'(dm2), 1);
        chk("pl2_mem_cnt", int'(cnt2), 1);
        r2 = 1'b1;
        tick();
        chk("pl2_rst_clks", int'({im2, dm2, pc2, rc2}), 0);
        chk("pl2_rst_run_ph", int'({run2, ph2}), 0);
        chk("pl2_rst_cnt", int'(cnt2), 0);
        r2 = 1'b0;
        tick();
        chk("pl2_release_imem", int'({im2, dm2, pc2, rc2, run2, ph2}), int'(7'b1000_1_00));

`ifdef STEP_PHASE_EN
        // Park u1 in HOLD, then step.
        h1 = 1'b1;
        s1 = 1'b0;
        waited = 0;
        while (run1 !== 1'b0 && waited < 12) begin
            tick();
            waited++;
        end
        chk("step_hold_entry", int'(run1), 0);
        tick();
        base = cnt1;
        pim = im1; pdm = dm1; ppc = pc1;
        n_im = 0; n_dm = 0; n_pc = 0;
        count_pulses(1, 1'b1);
        chk("step_running", int'(run1), 1);
        count_pulses(15, 1'b0);
        chk("step_imem_pulses", n_im, 1);
        chk("step_dmem_pulses", n_dm, 1);
        chk("step_proc_pulses", n_pc, 1);
        chk("step_cnt", int'(cnt1), int'(base + 4'd1));
        chk("step_back_hold", int'(out1()), int'(7'b0000_0_11));

        base = cnt1;
        n_im = 0; n_dm = 0; n_pc = 0;
        count_pulses(20, 1'b1);
        chk("stephold_imem_pulses", n_im, 1);
        chk("stephold_proc_pulses", n_pc, 1);
        chk("stephold_cnt", int'(cnt1), int'(base + 4'd1));
        chk("stephold_back_hold", int'(run1), 0);
        s1 = 1'b0;
`else
        waited = 0;
        base = 4'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
